// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer.
// Each raw input passes through a two-flop synchroniser, then its own 4-state
// qualification FSM. Outputs are a clean level per channel, one-cycle rise and
// fall pulses aligned with the level change, and a busy flag that is high
// while any channel is qualifying a candidate level. All outputs are registered.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  // Derived from DEBOUNCE_CYCLES; leave at its default.
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             busy
);

  // Count value on which the next matching sample accepts the new level.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  // With a one-sample window a change is accepted without a WAIT state.
  localparam bit SingleSample = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    StStableLow,
    StWaitHigh,
    StStableHigh,
    StWaitLow
  } state_e;

  logic [WIDTH-1:0] s1_q, s2_q;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             busy_q, busy_d;

  // Two-flop synchroniser; the FSMs only ever look at s2_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  // Per-channel qualification: next state, counter and registered outputs.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StStableLow: begin
          if (s2_q[i]) begin
            if (SingleSample) begin
              state_d[i] = StStableHigh;
              db_d[i]    = 1'b1;
              rise_d[i]  = 1'b1;
            end else begin
              state_d[i] = StWaitHigh;
              cnt_d[i]   = CntOne;
            end
          end
        end
        StWaitHigh: begin
          if (!s2_q[i]) begin
            // Bounce back to the old level: drop the attempt entirely.
            state_d[i] = StStableLow;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStableHigh;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StStableHigh: begin
          if (!s2_q[i]) begin
            if (SingleSample) begin
              state_d[i] = StStableLow;
              db_d[i]    = 1'b0;
              fall_d[i]  = 1'b1;
            end else begin
              state_d[i] = StWaitLow;
              cnt_d[i]   = CntOne;
            end
          end
        end
        StWaitLow: begin
          if (s2_q[i]) begin
            state_d[i] = StStableHigh;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStableLow;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StStableLow;
          cnt_d[i]   = '0;
          db_d[i]    = 1'b0;
        end
      endcase
      if (state_d[i] == StWaitHigh || state_d[i] == StWaitLow) begin
        busy_d = 1'b1;
      end
    end
  end

  // State, counter and output registers; reset drops db_out without a fall pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= StStableLow;
        cnt_q[i]   <= '0;
      end
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      busy_q <= busy_d;
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: four instances with different widths and
// debounce windows, hand-written sequences with constant expectations, a
// per-cycle vector table, and randomised bouncing inputs checked against a
// run-length reference model.
module tb_switch_debouncer;

  logic clk;
  logic rst;

  logic [3:0] raw_a, db_a, ri_a, fa_a;
  logic       bz_a;
  logic [0:0] raw_b, db_b, ri_b, fa_b;
  logic       bz_b;
  logic [0:0] raw_c, db_c, ri_c, fa_c;
  logic       bz_c;
  logic [1:0] raw_d, db_d, ri_d, fa_d;
  logic       bz_d;

  int n_cmp;
  int n_err;

  switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .raw_in(raw_a), .db_out(db_a),
    .rise_pulse(ri_a), .fall_pulse(fa_a), .busy(bz_a)
  );
  switch_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(16)) u_b (
    .clk(clk), .rst(rst), .raw_in(raw_b), .db_out(db_b),
    .rise_pulse(ri_b), .fall_pulse(fa_b), .busy(bz_b)
  );
  switch_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .raw_in(raw_c), .db_out(db_c),
    .rise_pulse(ri_c), .fall_pulse(fa_c), .busy(bz_c)
  );
  switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) u_d (
    .clk(clk), .rst(rst), .raw_in(raw_d), .db_out(db_d),
    .rise_pulse(ri_d), .fall_pulse(fa_d), .busy(bz_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A new level is accepted once D consecutive synchronised samples (raw
  // delayed by two clocks) differ from the current level.
  function automatic int d_of(input int k);
    case (k)
      0:       return 4;
      1:       return 16;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  logic [3:0] mraw [4];
  assign mraw[0] = raw_a;
  assign mraw[1] = {3'b000, raw_b};
  assign mraw[2] = {3'b000, raw_c};
  assign mraw[3] = {2'b00, raw_d};

  logic [3:0] h1 [4];
  logic [3:0] h2 [4];
  logic [3:0] mdb [4];
  logic [3:0] mrise [4];
  logic [3:0] mfall [4];
  int         run [4][4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        h1[k]    <= '0;
        h2[k]    <= '0;
        mdb[k]   <= '0;
        mrise[k] <= '0;
        mfall[k] <= '0;
        for (int c = 0; c < 4; c++) run[k][c] <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        h1[k] <= mraw[k];
        h2[k] <= h1[k];
        for (int c = 0; c < 4; c++) begin
          if (h2[k][c] != mdb[k][c]) begin
            if (run[k][c] + 1 == d_of(k)) begin
              mdb[k][c]   <= h2[k][c];
              mrise[k][c] <= h2[k][c];
              mfall[k][c] <= ~h2[k][c];
              run[k][c]   <= 0;
            end else begin
              run[k][c]   <= run[k][c] + 1;
              mrise[k][c] <= 1'b0;
              mfall[k][c] <= 1'b0;
            end
          end else begin
            run[k][c]   <= 0;
            mrise[k][c] <= 1'b0;
            mfall[k][c] <= 1'b0;
          end
        end
      end
    end
  end

  function automatic logic model_busy(input int k);
    logic b;
    b = 1'b0;
    for (int c = 0; c < 4; c++) if (run[k][c] != 0) b = 1'b1;
    return b;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [3:0] adb, ar, af;
    logic       ab;
    for (int k = 0; k < 4; k++) begin
      adb = '0; ar = '0; af = '0; ab = 1'b0;
      case (k)
        0: begin adb = db_a; ar = ri_a; af = fa_a; ab = bz_a; end
        1: begin adb = {3'b000, db_b}; ar = {3'b000, ri_b}; af = {3'b000, fa_b}; ab = bz_b; end
        2: begin adb = {3'b000, db_c}; ar = {3'b000, ri_c}; af = {3'b000, fa_c}; ab = bz_c; end
        default: begin adb = {2'b00, db_d}; ar = {2'b00, ri_d}; af = {2'b00, fa_d}; ab = bz_d; end
      endcase
      check($sformatf("model_db%0d", k), adb, mdb[k]);
      check($sformatf("model_rise%0d", k), ar, mrise[k]);
      check($sformatf("model_fall%0d", k), af, mfall[k]);
      check($sformatf("model_busy%0d", k), {3'b000, ab}, {3'b000, model_busy(k)});
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_db"}, db_a | {3'b000, db_b} | {3'b000, db_c} | {2'b00, db_d}, 4'b0000);
    check({tag, "_pulse"}, ri_a | fa_a | {3'b000, ri_b | fa_b | ri_c | fa_c} |
          {2'b00, ri_d | fa_d}, 4'b0000);
    check({tag, "_busy"}, {3'b000, bz_a | bz_b | bz_c | bz_d}, 4'b0000);
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    compare_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] raw;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } vec_t;

  // ---------------- stimulus ----------------
  initial begin
    vec_t       tbl [16];
    logic [1:0] pat [10];
    logic [1:0] r1, r2, dprev;

    n_cmp = 0;
    n_err = 0;
    raw_a = '0; raw_b = '0; raw_c = '0; raw_d = '0;
    rst   = 1'b0;

    // Multi-channel schedule on instance A (D=4): row i applied before edge i.
    tbl = '{
      '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0},
      '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0},
      '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b1101, 4'b0101, 4'b0101, 4'b0000, 1'b1},
      '{4'b1101, 4'b0101, 4'b0000, 4'b0000, 1'b1},
      '{4'b1101, 4'b1101, 4'b1000, 4'b0000, 1'b0},
      '{4'b1100, 4'b1101, 4'b0000, 4'b0000, 1'b0},
      '{4'b1010, 4'b1101, 4'b0000, 4'b0000, 1'b0},
      '{4'b1010, 4'b1101, 4'b0000, 4'b0000, 1'b1},
      '{4'b1010, 4'b1101, 4'b0000, 4'b0000, 1'b1},
      '{4'b1010, 4'b1101, 4'b0000, 4'b0000, 1'b1},
      '{4'b1010, 4'b1100, 4'b0000, 4'b0001, 1'b1},
      '{4'b1010, 4'b1010, 4'b0010, 4'b0100, 1'b0},
      '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0}
    };
    pat = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11};

    // Reset state, then hold reset for three edges.
    #1 rst = 1'b1;
    #1;
    check_all_zero("reset");
    compare_model();
    repeat (3) tick();
    rst = 1'b0;

    // Clean press on A bit 0: raw high from edge 2.
    tick();
    raw_a = 4'b0001;
    for (int e = 2; e <= 8; e++) begin
      tick();
      check($sformatf("press_db_e%0d", e), db_a, {3'b000, e >= 7});
      check($sformatf("press_rise_e%0d", e), ri_a, {3'b000, e == 7});
      check($sformatf("press_busy_e%0d", e), {3'b000, bz_a}, {3'b000, e >= 4 && e <= 6});
    end

    // Bounce on A bit 1, then a clean hold.
    for (int b = 0; b < 4; b++) begin
      raw_a[1] = (b % 2 == 0);
      tick();
      check($sformatf("bounce_rise_b%0d", b), ri_a, 4'b0000);
      check($sformatf("bounce_db_b%0d", b), db_a, 4'b0001);
    end
    raw_a[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("settle_db_e%0d", e), db_a, {2'b00, e >= 6, 1'b1});
      check($sformatf("settle_rise_e%0d", e), ri_a, {2'b00, e == 6, 1'b0});
    end

    // Instance B (D=16): reach high, reject a 10-cycle low glitch, then release.
    raw_b = 1'b1;
    repeat (20) tick();
    check("b_high", {3'b000, db_b}, 4'b0001);
    raw_b = 1'b0;
    repeat (10) begin
      tick();
      check("b_glitch_fall", {3'b000, fa_b}, 4'b0000);
    end
    raw_b = 1'b1;
    repeat (20) begin
      tick();
      check("b_glitch_db", {3'b000, db_b}, 4'b0001);
      check("b_glitch_fall2", {3'b000, fa_b}, 4'b0000);
    end
    raw_b = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("b_rel_fall_e%0d", e), {3'b000, fa_b}, {3'b000, e == 18});
      check($sformatf("b_rel_db_e%0d", e), {3'b000, db_b}, {3'b000, e < 18});
    end

    // Table-driven multi-channel run on A from a fresh reset.
    raw_a = '0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      raw_a = tbl[i].raw;
      tick();
      check($sformatf("tbl%0d_db", i), db_a, tbl[i].db);
      check($sformatf("tbl%0d_rise", i), ri_a, tbl[i].rise);
      check($sformatf("tbl%0d_fall", i), fa_a, tbl[i].fall);
      check($sformatf("tbl%0d_busy", i), {3'b000, bz_a}, {3'b000, tbl[i].busy});
    end

    // Instance C (D=8): reset in the middle of qualification.
    raw_a = '0;
    raw_c = 1'b1;
    repeat (5) tick();
    check("c_busy_mid", {3'b000, bz_c}, 4'b0001);
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("c_rise_e%0d", e), {3'b000, ri_c}, {3'b000, e == 10});
      check($sformatf("c_db_e%0d", e), {3'b000, db_c}, {3'b000, e >= 10});
      check($sformatf("c_fall_e%0d", e), {3'b000, fa_c}, 4'b0000);
    end

    // Instance D (D=1): db follows raw two edges late, pulse on every change.
    r1 = 2'b00; r2 = 2'b00; dprev = 2'b00;
    for (int e = 0; e < 10; e++) begin
      raw_d = pat[e];
      tick();
      check($sformatf("d1_db_e%0d", e), {2'b00, db_d}, {2'b00, r2});
      check($sformatf("d1_rise_e%0d", e), {2'b00, ri_d}, {2'b00, r2 & ~dprev});
      check($sformatf("d1_fall_e%0d", e), {2'b00, fa_d}, {2'b00, ~r2 & dprev});
      dprev = r2;
      r2    = r1;
      r1    = pat[e];
    end

    // Randomised bouncing on every instance, model checked each edge.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(6, 0) == 0) raw_a[c] = ~raw_a[c];
      if ($urandom_range(19, 0) == 0) raw_b = ~raw_b;
      if ($urandom_range(10, 0) == 0) raw_c = ~raw_c;
      for (int c = 0; c < 2; c++) if ($urandom_range(2, 0) == 0) raw_d[c] = ~raw_d[c];
      if ($urandom_range(599, 0) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
